burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
- Memory-side responder for the 4-beat x 64-bit burst protocol driven by cacheline_adaptor. It connects to the adaptor's memory port and serves as the synthesizable backing memory for LLC bring-up and regression.
- On a read it returns one 256-bit line as four 64-bit beats. On a write it stores four beats into one line.
- Programmable first-beat latency.

Parameters:
- DEPTH, 256, number of 256-bit lines stored (power of 2).
- LATENCY, 2, idle cycles between request acceptance and first beat (0..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- address_i  in  32  line address from adaptor; bits [4:0] ignored
- read_i  in  1  read request, held high for the whole burst
- write_i  in  1  write request, held high for the whole burst
- burst_i  in  64  write beat data from adaptor
- burst_o  out  64  read beat data to adaptor
- resp_o  out  1  beat strobe; one beat transferred per high cycle

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, beat counter=0, latency counter=0, resp_o=0, burst_o=0. Array contents are not reset.
- Line index: address_i[5 +: log2(DEPTH)]. Upper bits are ignored, so addresses wrap modulo DEPTH.
- States: IDLE, LAT, BEAT.
- IDLE:
  - If read_i or write_i is sampled high: latch index and op (write has priority when both are high).
  - Clear counters.
  - Go to LAT, or directly to BEAT if LATENCY=0.
- LAT:
  - Count LATENCY cycles with resp_o=0, then go to BEAT.
- BEAT:
  - Four consecutive cycles, beat k=0..3, with resp_o=1.
  - After beat 3, return to IDLE.
- Timing: if the request is first high in cycle t, resp_o is high exactly in cycles t+1+LATENCY through t+4+LATENCY.
  - resp_o and burst_o are registered outputs.
- Read beat k: burst_o = line[64k+63:64k] in the same cycle resp_o=1. burst_o=0 whenever resp_o=0.
- Write beat k: burst_i is sampled at the clock edge ending the resp_o=1 cycle of beat k and written to line[64k+63:64k]. Other beats of the line are untouched.
- Latched index and op are authoritative for the whole transaction. Changes on address_i or the op during LAT or BEAT are ignored.
- Abort: if read_i and write_i are both low in any LAT or BEAT cycle:
  - Return to IDLE next cycle; resp_o=0 next cycle.
  - No further beats are written. Beats already written remain.
- Back-to-back: IDLE accepts a new request on the first cycle after the final beat. The adaptor's DONE/HALT gap guarantees a deasserted request in between.
- Read-after-write to the same line returns the newly written data, with no hazard window.
- Reset asserted mid-burst: outputs clear immediately. A partially written line keeps the beats completed so far.

Decomposition:
- Package burst_mem_pkg holds:
  - BEATS=4, BEAT_W=64, LINE_W=256, OFFSET_W=5
  - state enum type (IDLE, LAT, BEAT)
  - beat index type logic [1:0]
- One sub-module, burst_mem_array (parameter DEPTH):
  - One 256-bit line per entry.
  - Beat-granular write port (index, beat, 64-bit data, we).
  - Registered beat read port (index, beat → 64-bit data).
  - No reset on storage.
- The top holds the FSM, counters and request latches.

Test Plan:
- Reset then idle, LATENCY=2 → resp_o=0 and burst_o=0 for 20 cycles; array not touched.
- Write then read: write line 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → resp_o high exactly cycles t+3..t+6. A later read of 0x0000_0040 returns the same four beats in order, with burst_o valid on resp_o cycles.
- LATENCY=0: read request at cycle t → resp_o high cycles t+1..t+4. Address 0x0000_005F reads the same line as 0x0000_0040.
- Wrap: DEPTH=256, write 0x0000_2000 then read 0x0000_0000 → identical data (index wraps).
- Abort: write request, drop write_i after beat 1 → beats 0-1 updated, beats 2-3 keep old values; resp_o low the cycle after the drop.
- Both read_i and write_i high → write performed; burst_o stays 0. Reset pulse during beat 2 → resp_o and burst_o clear asynchronously, and the next request starts fresh at beat 0.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared types and widths for the 4-beat x 64-bit burst memory responder.
package burst_mem_pkg;

    localparam int BEATS    = 4;
    localparam int BEAT_W   = 64;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        BEAT
    } state_t;

    typedef logic [1:0] beat_idx_t;

endpackage

// File: rtl/burst_mem_responder_if.sv
// Adaptor-to-memory burst bus; the adaptor is the master, the responder the slave.
interface burst_mem_responder_if;
    import burst_mem_pkg::*;

    logic [31:0]       address_i;
    logic              read_i;
    logic              write_i;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic              resp_o;

    modport master (
        output address_i, read_i, write_i, burst_i,
        input  burst_o, resp_o
    );

    modport slave (
        input  address_i, read_i, write_i, burst_i,
        output burst_o, resp_o
    );

endinterface

// File: rtl/burst_mem_array.sv
// Line storage with beat-granular writes and a registered beat read port.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  beat_idx_t         wr_beat,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_index,
    input  beat_idx_t         rd_beat,
    output logic [BEAT_W-1:0] rd_data
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index][wr_beat*BEAT_W +: BEAT_W] <= wr_data;
        end
    end

    // The read register doubles as the bus output, so it reads zero whenever no beat is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_index][rd_beat*BEAT_W +: BEAT_W];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: accepts a line request, waits LATENCY cycles, then moves four beats.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    burst_mem_responder_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state;
    beat_idx_t         beat_cnt;
    logic [3:0]        lat_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              op_write;
    logic              resp_q;

    logic              req;
    logic [IDX_W-1:0]  addr_idx;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_index;
    beat_idx_t         rd_beat;
    logic [BEAT_W-1:0] rd_data;
    logic              unused_addr;

    assign req         = bus.read_i | bus.write_i;
    assign addr_idx    = bus.address_i[OFFSET_W +: IDX_W];
    assign unused_addr = ^{bus.address_i[OFFSET_W-1:0], bus.address_i[31:OFFSET_W+IDX_W]};

    // Dropping both request lines in LAT or BEAT aborts the transaction on the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            idx_q    <= '0;
            op_write <= 1'b0;
            resp_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    lat_cnt  <= '0;
                    if (req) begin
                        idx_q    <= addr_idx;
                        op_write <= bus.write_i;
                        if (LATENCY == 0) begin
                            state  <= BEAT;
                            resp_q <= 1'b1;
                        end else begin
                            state <= LAT;
                        end
                    end
                end
                LAT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (lat_cnt == LAT_LAST) begin
                        state  <= BEAT;
                        resp_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                BEAT: begin
                    if (!req || beat_cnt == 2'd3) begin
                        state  <= IDLE;
                        resp_q <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
            endcase
        end
    end

    // Address the read port one cycle ahead so the beat lands in the register alongside resp_o.
    always_comb begin
        rd_en    = 1'b0;
        rd_index = idx_q;
        rd_beat  = beat_cnt + 2'd1;
        case (state)
            IDLE: begin
                rd_index = addr_idx;
                rd_beat  = '0;
                rd_en    = (LATENCY == 0) && bus.read_i && !bus.write_i;
            end
            LAT: begin
                rd_beat = '0;
                rd_en   = req && !op_write && (lat_cnt == LAT_LAST);
            end
            BEAT: begin
                rd_en = req && !op_write && (beat_cnt != 2'd3);
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

    assign wr_en = (state == BEAT) && op_write && req;

    burst_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_index (idx_q),
        .wr_beat  (beat_cnt),
        .wr_data  (bus.burst_i),
        .rd_en    (rd_en),
        .rd_index (rd_index),
        .rd_beat  (rd_beat),
        .rd_data  (rd_data)
    );

    assign bus.resp_o  = resp_q;
    assign bus.burst_o = rd_data;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 0 and 2) checked against a line-level memory model.
module tb_burst_mem_responder;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          cyc;
    int          tests;
    int          fails;
    bit          check_en;

    logic [63:0] model [2][256][4];
    exp_t        q0[$];
    exp_t        q2[$];

    burst_mem_responder_if bus0 ();
    burst_mem_responder_if bus2 ();

    assign bus0.address_i = addr;
    assign bus0.burst_i   = wdata;
    assign bus0.read_i    = rd & !sel;
    assign bus0.write_i   = wr & !sel;
    assign bus2.address_i = addr;
    assign bus2.burst_i   = wdata;
    assign bus2.read_i    = rd & sel;
    assign bus2.write_i   = wr & sel;

    burst_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    burst_mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int q_size(input int s);
        return s ? q2.size() : q0.size();
    endfunction

    function automatic exp_t q_front(input int s);
        return s ? q2[0] : q0[0];
    endfunction

    function automatic exp_t q_pop(input int s);
        if (s != 0) return q2.pop_front();
        return q0.pop_front();
    endfunction

    task automatic push_exp(input int s, input exp_t e);
        if (s != 0) q2.push_back(e);
        else q0.push_back(e);
    endtask

    // Compare one DUT's outputs for the current cycle against the head of its queue.
    task automatic check_output(input int s);
        logic        r;
        logic [63:0] d;
        exp_t        e;
        r = s ? bus2.resp_o : bus0.resp_o;
        d = s ? bus2.burst_o : bus0.burst_o;
        tests++;
        if (r === 1'b1) begin
            if (q_size(s) == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_beat lat%0d cycle %0d: got resp_o=1 burst_o=%h, required resp_o=0", s * 2, cyc, d);
            end else begin
                e = q_pop(s);
                if (e.cyc != cyc || d !== e.data) begin
                    fails++;
                    $display("[TB] FAIL beat lat%0d: got cycle %0d data %h, required cycle %0d data %h", s * 2, cyc, d, e.cyc, e.data);
                end
            end
        end else begin
            if (r !== 1'b0 || d !== 64'h0) begin
                fails++;
                $display("[TB] FAIL idle_outputs lat%0d cycle %0d: got resp_o=%b burst_o=%h, required 0/0", s * 2, cyc, r, d);
            end
            if (q_size(s) != 0 && q_front(s).cyc <= cyc) begin
                e = q_pop(s);
                tests++;
                fails++;
                $display("[TB] FAIL missing_beat lat%0d: got resp_o=0 at cycle %0d, required beat %h at cycle %0d", s * 2, cyc, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output(0);
            check_output(1);
        end
    end

    // Hold a request for 'hold' cycles; the model works out which beats appear and which get written.
    task automatic apply_stimulus(input int s, input bit r, input bit w, input logic [31:0] a,
                                  input int hold, input logic [255:0] line);
        int   lat;
        int   idx;
        int   shown;
        int   writes;
        int   t;
        int   k;
        exp_t e;
        lat    = s ? 2 : 0;
        idx    = int'((a >> 5) % 256);
        shown  = hold - lat;
        writes = hold - lat - 1;
        if (shown > 4) shown = 4;
        if (shown < 0) shown = 0;
        if (writes > 4) writes = 4;
        if (writes < 0) writes = 0;
        @(posedge clk);
        #1;
        t     = cyc;
        sel   = (s != 0);
        addr  = a;
        rd    = r;
        wr    = w;
        wdata = {$urandom, $urandom};
        for (int i = 0; i < shown; i++) begin
            e.cyc  = t + 1 + lat + i;
            e.data = w ? 64'h0 : model[s][idx][i];
            push_exp(s, e);
        end
        if (w) begin
            for (int i = 0; i < writes; i++) model[s][idx][i] = line[i*64 +: 64];
        end
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
            k = i - 1 - lat;
            wdata = (k >= 0 && k < 4) ? line[k*64 +: 64] : {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = $urandom;
    endtask

    // Write on the LATENCY=2 responder and pull reset while beat 2 is on the bus.
    task automatic reset_mid_burst(input logic [31:0] a, input logic [255:0] line);
        int   idx;
        int   t;
        exp_t e;
        idx = int'((a >> 5) % 256);
        @(posedge clk);
        #1;
        t    = cyc;
        sel  = 1'b1;
        addr = a;
        wr   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e.cyc  = t + 3 + i;
            e.data = 64'h0;
            push_exp(1, e);
            model[1][idx][i] = line[i*64 +: 64];
        end
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            wdata = (i >= 3) ? line[(i-3)*64 +: 64] : 64'h0;
        end
        #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus2.resp_o !== 1'b0 || bus2.burst_o !== 64'h0) begin
            fails++;
            $display("[TB] FAIL async_reset_clear: got resp_o=%b burst_o=%h, required 0/0", bus2.resp_o, bus2.burst_o);
        end
        wr = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] pat;
        int           s;
        int           op;
        int           hold;
        tests    = 0;
        fails    = 0;
        check_en = 1'b0;
        sel      = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        reset_n  = 1'b1;
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n  = 1'b1;
        check_en = 1'b1;

        repeat (20) @(posedge clk);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                apply_stimulus(d, 1'b0, 1'b1, 32'(i) << 5, 5 + 2 * d, rand_line());
            end
        end

        pat = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_0040, 7, pat);
        apply_stimulus(1, 1'b1, 1'b0, 32'h0000_0040, 7, '0);
        apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0040, 5, pat);
        apply_stimulus(0, 1'b1, 1'b0, 32'h0000_005F, 5, '0);
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_2000, 7, rand_line());
        apply_stimulus(1, 1'b1, 1'b0, 32'h0000_0000, 7, '0);
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_0080, 5, rand_line());
        apply_stimulus(1, 1'b1, 1'b0, 32'h0000_0080, 7, '0);
        apply_stimulus(1, 1'b1, 1'b1, 32'h0000_00A0, 7, rand_line());
        apply_stimulus(1, 1'b1, 1'b0, 32'h0000_00A0, 7, '0);

        reset_mid_burst(32'h0000_00C0, rand_line());
        apply_stimulus(1, 1'b1, 1'b0, 32'h0000_00C0, 7, '0);
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_00C0, 7, rand_line());
        apply_stimulus(1, 1'b1, 1'b0, 32'h0000_00C0, 7, '0);

        for (int n = 0; n < 300; n++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) hold = int'($urandom_range(1, 4 + 2 * s));
            else hold = 5 + 2 * s;
            apply_stimulus(s, op != 2, op >= 2, $urandom, hold, rand_line());
        end

        repeat (10) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (q_size(d) != 0) begin
                fails++;
                $display("[TB] FAIL drain lat%0d: got %0d beats outstanding, required 0", d * 2, q_size(d));
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
